// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and defaults for the wired-bus arbiter: FSM states,
// default sizing, and the pull-up level the bus floats to when undriven.
package shared_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int DEF_N        = 4;
  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_HOLD = 8;

  // Every bus bit floats high when nobody drives (wired-AND with pull-ups).
  localparam logic IDLE_BUS_LEVEL = 1'b1;

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Round-robin priority picker: first requester at or after ptr, wrapping
// N-1 -> 0. Purely combinational.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 any_req
);

  int idx;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; a missing default here would infer a latch.
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = ($clog2(N))'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Arbiter for N requesters on one wired bus: round-robin grant, hold limit
// when others wait, and a one-cycle TURN gap between consecutive drivers.
module shared_bus_arbiter
  import shared_bus_arbiter_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int DW       = DEF_DW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      data_in,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         bus_oe,
  output logic [DW-1:0]        bus_data,
  output logic                 bus_busy,
  output logic [$clog2(N)-1:0] owner
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [HW-1:0] hold;
  logic [PW-1:0] winner;
  logic          any_req;
  logic          others_req;
  logic [PW-1:0] next_ptr;
  logic          hold_full;

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign others_req = |(req & ~gnt);
  assign next_ptr   = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
  assign hold_full  = (hold == HW'(MAX_HOLD));

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      owner <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (any_req) begin
            state <= GRANT;
            gnt   <= {{(N-1){1'b0}}, 1'b1} << winner;
            owner <= winner;
            ptr   <= next_ptr;
            hold  <= HW'(1);
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // Release on owner drop, or preempt once the hold budget is spent
          // and someone else is waiting; a lone owner keeps the bus.
          if (!req[owner] || (hold_full && others_req)) begin
            state <= TURN;
            gnt   <= '0;
            hold  <= '0;
          end else if (!hold_full) begin
            hold <= hold + HW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          hold  <= '0;
        end
      endcase
    end
  end

  assign bus_oe   = gnt;
  assign bus_busy = (state != IDLE);

  // Bus value is the owner's data while granted, otherwise the pull-up level;
  // a pending reset also forces the idle level immediately.
  always_comb begin
    bus_data = {DW{IDLE_BUS_LEVEL}};
    if (state == GRANT && !rst) bus_data = data_in[int'(owner)*DW +: DW];
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter: single request, full round-robin,
// hold-limit preemption, lone holder and mid-grant reset.
module tb_shared_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  gnt;
  logic [N-1:0]  bus_oe;
  logic [DW-1:0] bus_data;
  logic          bus_busy;
  logic [1:0]    owner;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_gnt;

  shared_bus_arbiter #(.N(N), .DW(DW), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .gnt      (gnt),
    .bus_oe   (bus_oe),
    .bus_data (bus_data),
    .bus_busy (bus_busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    check("onehot_or_zero", 32'(((gnt & (gnt - 1'b1)) == '0)), 32'd1);
    check("bus_oe_eq_gnt", 32'(bus_oe), 32'(gnt));
    if (gnt == '0) check("idle_bus_ones", 32'(bus_data), 32'hFF);
  end

  initial begin
    rst     = 1'b1;
    req     = '0;
    data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(bus_busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_bus", 32'(bus_data), 32'hFF);
    rst = 1'b0;

    // Single request: req=0010 for cycles 1-3.
    req = 4'b0010;
    tick();
    check("s1_c2_gnt", 32'(gnt), 32'h2);
    check("s1_c2_bus", 32'(bus_data), 32'hB1);
    check("s1_c2_owner", 32'(owner), 32'h1);
    check("s1_c2_busy", 32'(bus_busy), 32'h1);
    tick();
    check("s1_c3_gnt", 32'(gnt), 32'h2);
    tick();
    req = 4'b0000;
    check("s1_c4_gnt", 32'(gnt), 32'h2);
    check("s1_c4_bus", 32'(bus_data), 32'hB1);
    tick();
    check("s1_c5_turn_gnt", 32'(gnt), 32'h0);
    check("s1_c5_turn_busy", 32'(bus_busy), 32'h1);
    check("s1_c5_turn_bus", 32'(bus_data), 32'hFF);
    tick();
    check("s1_c6_idle_busy", 32'(bus_busy), 32'h0);
    check("s1_c6_owner_kept", 32'(owner), 32'h1);

    // Simultaneous requests: order 0,1,2,3,0, each 8 cycles then one TURN.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      for (int c = 0; c < 8; c++) begin
        tick();
        check($sformatf("s2_g%0d_c%0d", k, c), 32'(gnt), 32'(exp_gnt));
        check($sformatf("s2_bus%0d_c%0d", k, c), 32'(bus_data), 32'(8'hA0 + 8'(k % 4) * 8'h11));
      end
      if (k < 4) begin
        tick();
        check($sformatf("s2_turn%0d", k), 32'(gnt), 32'h0);
        check($sformatf("s2_turn_busy%0d", k), 32'(bus_busy), 32'h1);
      end
    end
    req = 4'b0000;
    tick();
    tick();
    check("s2_end_idle", 32'(bus_busy), 32'h0);

    // Hold limit: req[0] from cycle 1, req[2] joins at cycle 3.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0001;
    tick();
    check("s3_g_c2", 32'(gnt), 32'h1);
    tick();
    req = 4'b0101;
    check("s3_g_c3", 32'(gnt), 32'h1);
    for (int c = 4; c <= 9; c++) begin
      tick();
      check($sformatf("s3_g_c%0d", c), 32'(gnt), 32'h1);
    end
    tick();
    check("s3_turn", 32'(gnt), 32'h0);
    check("s3_turn_busy", 32'(bus_busy), 32'h1);
    tick();
    check("s3_new_gnt", 32'(gnt), 32'h4);
    check("s3_new_owner", 32'(owner), 32'h2);
    check("s3_new_bus", 32'(bus_data), 32'hC2);

    // Reset mid-grant: bus idles at once, grant drops with no TURN.
    rst = 1'b1;
    req = 4'b1111;
    #1;
    check("s5_bus_during_rst", 32'(bus_data), 32'hFF);
    tick();
    check("s5_gnt_dropped", 32'(gnt), 32'h0);
    check("s5_busy_dropped", 32'(bus_busy), 32'h0);
    check("s5_bus_ones", 32'(bus_data), 32'hFF);
    check("s5_owner_rst", 32'(owner), 32'h0);
    rst = 1'b0;
    tick();
    check("s5_regrant_0", 32'(gnt), 32'h1);

    // Lone holder: req[3] alone keeps the bus past MAX_HOLD.
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("s4_hold_c%0d", c), 32'(gnt), 32'h8);
    end
    check("s4_bus", 32'(bus_data), 32'hD3);
    data_in[31:24] = 8'h5A;
    #1;
    check("s4_bus_comb", 32'(bus_data), 32'h5A);
    req = 4'b0000;
    tick();
    check("s4_turn", 32'(gnt), 32'h0);
    check("s4_turn_busy", 32'(bus_busy), 32'h1);
    tick();
    check("s4_idle", 32'(bus_busy), 32'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
